// File: rtl/countdown_timer_if.sv
// -----------------------------------------------------------------------------
// countdown_timer_if
// Control/status bundle between a controller (software bridge or parent FSM)
// and countdown_timer. The clock and reset are kept as plain ports on the
// timer and are not part of this bundle.
//
// Signals:
//   load        controller -> timer  capture load_val into count and reload reg
//   load_val    controller -> timer  value captured on load
//   start       controller -> timer  begin or resume counting
//   stop        controller -> timer  pause counting, count held
//   enable      controller -> timer  decrement tick, honoured only while running
//   auto_reload controller -> timer  on expiry, reload and keep running
//   count       timer -> controller  current count (registered)
//   busy        timer -> controller  high while running (registered)
//   done        timer -> controller  one-cycle expiry pulse (registered)
// -----------------------------------------------------------------------------
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             stop;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  // Controller side.
  modport master (
    output load, load_val, start, stop, enable, auto_reload,
    input  count, busy, done
  );

  // Timer side.
  modport slave (
    input  load, load_val, start, stop, enable, auto_reload,
    output count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Loadable down-counter with an IDLE/RUN/PAUSE control FSM. A terminal count
// is loaded, counting is started, and every enable tick while running
// decrements the count. Reaching zero raises a one-cycle done pulse and either
// returns to IDLE or, with auto_reload, restarts from the reload register.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-low reset; clears count, reload register,
//        FSM, busy and done
//   t    countdown_timer_if.slave bundle (controls in, count/busy/done out)
//
// Control priority within one cycle: load > stop > start > enable.
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  countdown_timer_if.slave     t
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] rld_q;
  logic             busy_q;
  logic             done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      count_q <= '0;
      rld_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of state and count_q regardless of statement order.
      // done is a pulse: cleared every cycle unless a branch below sets it.
      done_q <= 1'b0;

      if (t.load) begin
        // Loading aborts any run in progress and suppresses a coincident expiry.
        count_q <= t.load_val;
        rld_q   <= t.load_val;
        state   <= IDLE;
        busy_q  <= 1'b0;
      end else if (t.stop) begin
        if (state == RUN) begin
          state  <= PAUSE;
          busy_q <= 1'b0;
        end
      end else if (t.start && (state != RUN)) begin
        if (count_q != '0) begin
          state  <= RUN;
          busy_q <= 1'b1;
        end else begin
          // Zero-length timer: expire immediately without entering RUN.
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end else if ((state == RUN) && t.enable) begin
        if (count_q > ONE) begin
          count_q <= count_q - ONE;
        end else if (count_q == ONE) begin
          done_q <= 1'b1;
          if (t.auto_reload && (rld_q != '0)) begin
            count_q <= rld_q;
          end else begin
            count_q <= '0;
            state   <= IDLE;
            busy_q  <= 1'b0;
          end
        end else begin
          // RUN is never entered with a zero count; recover to IDLE if it is.
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      end
    end
  end

  assign t.count = count_q;
  assign t.busy  = busy_q;
  assign t.done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Self-checking bench for countdown_timer: a directed vector table, hand-written
// multi-cycle sequences, and a randomized phase compared against a behavioural
// model that tracks only count, reload value and a "running" flag.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;

  countdown_timer_if #(.WIDTH(W)) bus ();

  countdown_timer #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .t   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: expiry rules expressed directly on integers.
  int m_count;
  int m_rld;
  bit m_run;
  bit m_done;

  typedef struct {
    bit         ld;
    logic [3:0] lv;
    bit         st;
    bit         sp;
    bit         en;
    bit         ar;
    logic [3:0] c;
    bit         b;
    bit         d;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    m_count = 0;
    m_rld   = 0;
    m_run   = 1'b0;
    m_done  = 1'b0;
  endfunction

  function automatic void model_step(input bit ld, input int lv, input bit st,
                                     input bit sp, input bit en, input bit ar);
    m_done = 1'b0;
    if (ld) begin
      m_count = lv;
      m_rld   = lv;
      m_run   = 1'b0;
    end else if (sp) begin
      m_run = 1'b0;
    end else if (st && !m_run) begin
      if (m_count != 0) m_run = 1'b1;
      else              m_done = 1'b1;
    end else if (m_run && en) begin
      if (m_count == 1) begin
        m_done = 1'b1;
        if (ar && m_rld != 0) m_count = m_rld;
        else begin
          m_count = 0;
          m_run   = 1'b0;
        end
      end else begin
        m_count = m_count - 1;
      end
    end
  endfunction

  // Drive one cycle of inputs at the falling edge, advance the model, and
  // return 1 ns after the rising edge so outputs can be sampled.
  task automatic apply(input bit ld, input logic [W-1:0] lv, input bit st,
                       input bit sp, input bit en, input bit ar);
    @(negedge clk);
    bus.load        = ld;
    bus.load_val    = lv;
    bus.start       = st;
    bus.stop        = sp;
    bus.enable      = en;
    bus.auto_reload = ar;
    model_step(ld, int'(lv), st, sp, en, ar);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    check({tag, " count"}, 32'(bus.count), 32'(m_count));
    check({tag, " busy"},  32'(bus.busy),  32'(m_run));
    check({tag, " done"},  32'(bus.done),  32'(m_done));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst             = 1'b0;
    bus.load        = 1'b0;
    bus.load_val    = '0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.enable      = 1'b0;
    bus.auto_reload = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin : main
    // ---------------- directed vector table ----------------
    //            ld lv  st sp en ar   count busy done
    tbl.push_back('{1, 4'd5, 0, 0, 0, 0, 4'd5, 0, 0}); // load 5
    tbl.push_back('{0, 4'd0, 1, 0, 0, 0, 4'd5, 1, 0}); // start
    tbl.push_back('{0, 4'd0, 0, 0, 1, 0, 4'd4, 1, 0});
    tbl.push_back('{0, 4'd0, 0, 0, 1, 0, 4'd3, 1, 0});
    tbl.push_back('{0, 4'd0, 0, 0, 1, 0, 4'd2, 1, 0});
    tbl.push_back('{0, 4'd0, 0, 0, 1, 0, 4'd1, 1, 0});
    tbl.push_back('{0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 1}); // terminal tick
    tbl.push_back('{0, 4'd0, 0, 0, 1, 0, 4'd0, 0, 0}); // done is one cycle
    tbl.push_back('{0, 4'd0, 1, 0, 0, 0, 4'd0, 0, 1}); // zero-count start
    tbl.push_back('{0, 4'd0, 0, 0, 0, 0, 4'd0, 0, 0});
    tbl.push_back('{1, 4'd3, 0, 0, 0, 0, 4'd3, 0, 0}); // load 3
    tbl.push_back('{0, 4'd0, 1, 0, 1, 0, 4'd3, 1, 0}); // start+enable: no dec
    tbl.push_back('{0, 4'd0, 0, 0, 1, 0, 4'd2, 1, 0});
    tbl.push_back('{0, 4'd0, 0, 0, 1, 0, 4'd1, 1, 0});
    tbl.push_back('{1, 4'd7, 0, 0, 1, 0, 4'd7, 0, 0}); // load beats terminal
    tbl.push_back('{0, 4'd0, 1, 0, 0, 0, 4'd7, 1, 0});
    tbl.push_back('{0, 4'd0, 0, 1, 1, 0, 4'd7, 0, 0}); // stop+enable
    tbl.push_back('{0, 4'd0, 0, 0, 1, 0, 4'd7, 0, 0}); // enable while paused
    tbl.push_back('{0, 4'd0, 1, 0, 0, 0, 4'd7, 1, 0}); // resume
    tbl.push_back('{0, 4'd0, 1, 0, 1, 0, 4'd6, 1, 0}); // start in RUN ignored

    do_reset();
    #1;
    check("reset count", 32'(bus.count), 32'd0);
    check("reset busy",  32'(bus.busy),  32'd0);
    check("reset done",  32'(bus.done),  32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].ld, tbl[i].lv, tbl[i].st, tbl[i].sp, tbl[i].en, tbl[i].ar);
      check($sformatf("vec%0d count", i), 32'(bus.count), 32'(tbl[i].c));
      check($sformatf("vec%0d busy", i),  32'(bus.busy),  32'(tbl[i].b));
      check($sformatf("vec%0d done", i),  32'(bus.done),  32'(tbl[i].d));
    end

    // ---------------- auto-reload from 3 ----------------
    do_reset();
    apply(1, 4'd3, 0, 0, 0, 1);
    apply(0, 4'd0, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) begin
      apply(0, 4'd0, 0, 0, 1, 1);
      check($sformatf("ar3 t%0d count", i), 32'(bus.count), 32'(3 - ((i + 1) % 3)));
      check($sformatf("ar3 t%0d busy", i),  32'(bus.busy),  32'd1);
      check($sformatf("ar3 t%0d done", i),  32'(bus.done),  32'((i % 3) == 2));
    end

    // ---------------- auto-reload from 1: done held high ----------------
    apply(1, 4'd1, 0, 0, 0, 1);
    apply(0, 4'd0, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      apply(0, 4'd0, 0, 0, 1, 1);
      check($sformatf("ar1 t%0d count", i), 32'(bus.count), 32'd1);
      check($sformatf("ar1 t%0d done", i),  32'(bus.done),  32'd1);
    end
    apply(0, 4'd0, 0, 0, 1, 0); // drop auto_reload: final expiry
    check("ar1 end busy", 32'(bus.busy), 32'd0);
    check("ar1 end done", 32'(bus.done), 32'd1);

    // ---------------- pause and resume from 9 ----------------
    apply(1, 4'd9, 0, 0, 0, 0);
    apply(0, 4'd0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) apply(0, 4'd0, 0, 0, 1, 0);
    check("pause pre count", 32'(bus.count), 32'd6);
    apply(0, 4'd0, 0, 1, 0, 0);
    check("pause busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      apply(0, 4'd0, 0, 0, 1, 0);
      check($sformatf("pause hold%0d count", i), 32'(bus.count), 32'd6);
    end
    apply(0, 4'd0, 1, 0, 0, 0);
    check("resume busy", 32'(bus.busy), 32'd1);
    apply(0, 4'd0, 0, 0, 1, 0);
    check("resume count5", 32'(bus.count), 32'd5);
    apply(0, 4'd0, 0, 0, 1, 0);
    check("resume count4", 32'(bus.count), 32'd4);
    cmp_model("resume model");

    // ---------------- asynchronous reset mid-run at count 4 ----------------
    @(negedge clk);
    bus.enable = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("async rst count", 32'(bus.count), 32'd0);
    check("async rst busy",  32'(bus.busy),  32'd0);
    check("async rst done",  32'(bus.done),  32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) apply(0, 4'd0, 0, 0, 1, 0);
    check("post rst count", 32'(bus.count), 32'd0);
    check("post rst busy",  32'(bus.busy),  32'd0);

    // ---------------- randomized against the model ----------------
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit         ld, st, sp, en, ar;
      logic [W-1:0] lv;
      ld = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 11) == 0);
      en = ($urandom_range(0, 2) != 0);
      ar = ($urandom_range(0, 1) == 1);
      lv = W'($urandom_range(0, (1 << W) - 1));
      apply(ld, lv, st, sp, en, ar);
      cmp_model($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
